// File: rtl/atm_pkg.sv
// rtl/atm_pkg.sv - key codes, session phase encoding and shared defaults for the ATM keypad front-end
package atm_pkg;

    localparam logic [3:0] KEY_ENTER    = 4'hA;
    localparam logic [3:0] KEY_CLEAR    = 4'hB;
    localparam logic [3:0] KEY_CANCEL   = 4'hC;
    localparam logic [3:0] KEY_DEPOSIT  = 4'hD;
    localparam logic [3:0] KEY_WITHDRAW = 4'hE;

    localparam int PIN_LEN_DEF = 4;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_SELECT      = 3'd1,
        S_PIN         = 3'd2,
        S_AMOUNT      = 3'd3,
        S_DONE        = 3'd4,
        S_WAIT_REMOVE = 3'd5,
        S_LOCKED      = 3'd6
    } state_t;

    function automatic logic is_digit(input logic [3:0] k);
        return (k <= 4'd9);
    endfunction

endpackage

// File: rtl/atm_amount_accum.sv
// rtl/atm_amount_accum.sv - decimal amount accumulator (clear, push digit, digit count, binary value)
module atm_amount_accum #(
    parameter int AMT_W      = 32,
    parameter int AMT_DIGITS = 9,
    localparam int CNT_W     = $clog2(AMT_DIGITS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [3:0]       digit,
    output logic [AMT_W-1:0] value,
    output logic [CNT_W-1:0] count
);

    // value = value*10 + digit using shifts; digits past AMT_DIGITS are dropped
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            value <= '0;
            count <= '0;
        end else if (push && (count < CNT_W'(AMT_DIGITS))) begin
            value <= (value << 3) + (value << 1) + AMT_W'(digit);
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/atm_keypad_frontend.sv
// rtl/atm_keypad_frontend.sv - keypad/card session front-end for the ATM controller (option: ATM_KEY_TIMEOUT_EN)
module atm_keypad_frontend
    import atm_pkg::*;
#(
    parameter int PIN_LEN    = PIN_LEN_DEF,
    parameter int AMT_W      = 32,
    parameter int AMT_DIGITS = 9
`ifdef ATM_KEY_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 1000000
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             card_in,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    input  logic             pin_incorrecto,
    input  logic             bloqueo,
    input  logic             balance_actualizado,
    input  logic             fondos_insuficientes,
    output logic             tarjeta_recibida,
    output logic             tipo_trans,
    output logic             add_digit,
    output logic [3:0]       digito,
    output logic             digito_stb,
    output logic             monto_stb,
    output logic [AMT_W-1:0] monto,
    output logic [2:0]       phase
);

    localparam int PIN_CW = $clog2(PIN_LEN + 1);
    localparam int AMT_CW = $clog2(AMT_DIGITS + 1);

    state_t              state, state_n;
    logic                card_q;
    logic [PIN_CW-1:0]   pin_cnt;
    logic [AMT_W-1:0]    acc_value;
    logic [AMT_CW-1:0]   amt_cnt;
    logic                timeout, cancel_ev, in_entry;
    logic                set_card, set_tipo, tipo_val, do_add, pin_done, pin_clr;
    logic                acc_clr, acc_push, monto_ld, go_idle;

    assign phase     = state;
    assign in_entry  = (state == S_SELECT) || (state == S_PIN) || (state == S_AMOUNT);
    assign cancel_ev = in_entry && ((key_valid && key_code == KEY_CANCEL) || timeout);

`ifdef ATM_KEY_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] idle_cnt;

    assign timeout = in_entry && !key_valid && (idle_cnt == TO_W'(TIMEOUT_CYC - 1));

    // count consecutive key-less cycles while a session is waiting for input
    always_ff @(posedge clk) begin
        if (rst || !in_entry || key_valid)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + TO_W'(1);
    end
`else
    assign timeout = 1'b0;
`endif

    atm_amount_accum #(
        .AMT_W      (AMT_W),
        .AMT_DIGITS (AMT_DIGITS)
    ) u_accum (
        .clk   (clk),
        .rst   (rst),
        .clear (acc_clr),
        .push  (acc_push),
        .digit (key_code),
        .value (acc_value),
        .count (amt_cnt)
    );

    // session state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    // next state and per-cycle actions; bloqueo > card removal > cancel > status > key
    always_comb begin
        state_n  = state;
        set_card = 1'b0;
        set_tipo = 1'b0;
        tipo_val = 1'b0;
        do_add   = 1'b0;
        pin_done = 1'b0;
        pin_clr  = 1'b0;
        acc_clr  = 1'b0;
        acc_push = 1'b0;
        monto_ld = 1'b0;
        go_idle  = 1'b0;
        if (bloqueo) begin
            state_n = S_LOCKED;
        end else if (state != S_IDLE && state != S_LOCKED && !card_in) begin
            state_n = S_IDLE;
            go_idle = 1'b1;
            pin_clr = 1'b1;
            acc_clr = 1'b1;
        end else if (cancel_ev) begin
            state_n = S_WAIT_REMOVE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (card_in && !card_q) begin
                        set_card = 1'b1;
                        state_n  = S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (key_valid && (key_code == KEY_DEPOSIT || key_code == KEY_WITHDRAW)) begin
                        set_tipo = 1'b1;
                        tipo_val = (key_code == KEY_WITHDRAW);
                        state_n  = S_PIN;
                    end
                end
                S_PIN: begin
                    if (key_valid) begin
                        if (is_digit(key_code)) begin
                            do_add = (pin_cnt < PIN_CW'(PIN_LEN));
                        end else if (key_code == KEY_ENTER && pin_cnt == PIN_CW'(PIN_LEN)) begin
                            pin_done = 1'b1;
                            state_n  = S_AMOUNT;
                        end else if (key_code == KEY_CLEAR) begin
                            pin_clr = 1'b1;
                        end
                    end
                end
                S_AMOUNT: begin
                    if (pin_incorrecto) begin
                        pin_clr = 1'b1;
                        acc_clr = 1'b1;
                        state_n = S_PIN;
                    end else if (key_valid) begin
                        if (is_digit(key_code)) begin
                            acc_push = 1'b1;
                        end else if (key_code == KEY_CLEAR) begin
                            acc_clr = 1'b1;
                        end else if (key_code == KEY_ENTER && amt_cnt != '0) begin
                            monto_ld = 1'b1;
                            state_n  = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (balance_actualizado || fondos_insuficientes)
                        state_n = S_WAIT_REMOVE;
                end
                default: ;
            endcase
        end
    end

    // registered outputs, PIN counter and card edge history
    always_ff @(posedge clk) begin
        if (rst) begin
            card_q           <= 1'b0;
            tarjeta_recibida <= 1'b0;
            add_digit        <= 1'b0;
            digito_stb       <= 1'b0;
            monto_stb        <= 1'b0;
            digito           <= 4'd0;
            pin_cnt          <= '0;
            tipo_trans       <= 1'b0;
            monto            <= '0;
        end else begin
            card_q           <= card_in;
            tarjeta_recibida <= set_card;
            add_digit        <= do_add;
            digito_stb       <= pin_done;
            monto_stb        <= monto_ld;
            if (do_add)
                digito <= key_code;
            if (pin_clr)
                pin_cnt <= '0;
            else if (do_add)
                pin_cnt <= pin_cnt + PIN_CW'(1);
            if (go_idle)
                tipo_trans <= 1'b0;
            else if (set_tipo)
                tipo_trans <= tipo_val;
            if (go_idle)
                monto <= '0;
            else if (monto_ld)
                monto <= acc_value;
        end
    end

endmodule

// File: tb/tb_atm_keypad_frontend.sv
// tb/tb_atm_keypad_frontend.sv - directed and randomized checks of atm_keypad_frontend against a session model
module tb_atm_keypad_frontend;
    import atm_pkg::*;

    localparam int TO_CYC = 16;
`ifdef ATM_KEY_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, card_in, key_valid, pin_incorrecto, bloqueo;
    logic        balance_actualizado, fondos_insuficientes;
    logic [3:0]  key_code;
    logic        tarjeta_recibida, tipo_trans, add_digit, digito_stb, monto_stb;
    logic [3:0]  digito;
    logic [31:0] monto;
    logic [2:0]  phase;

    int n_cmp = 0;
    int n_err = 0;
    int add_seen = 0;
    bit cur_card = 1'b0;

    // session model: digits kept as lists, amount evaluated arithmetically at ENTER
    state_t m_ph = S_IDLE;
    bit     m_card_prev = 1'b0;
    int     m_pin[$];
    int     m_amt[$];
    longint m_monto = 0;
    bit     m_tipo = 1'b0;
    int     m_digito = 0;
    int     m_quiet = 0;
    bit     p_card, p_add, p_pdone, p_mstb;

    always #5 clk = ~clk;

    atm_keypad_frontend #(
        .PIN_LEN    (4),
        .AMT_W      (32),
        .AMT_DIGITS (9)
`ifdef ATM_KEY_TIMEOUT_EN
        , .TIMEOUT_CYC (TO_CYC)
`endif
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .card_in              (card_in),
        .key_valid            (key_valid),
        .key_code             (key_code),
        .pin_incorrecto       (pin_incorrecto),
        .bloqueo              (bloqueo),
        .balance_actualizado  (balance_actualizado),
        .fondos_insuficientes (fondos_insuficientes),
        .tarjeta_recibida     (tarjeta_recibida),
        .tipo_trans           (tipo_trans),
        .add_digit            (add_digit),
        .digito               (digito),
        .digito_stb           (digito_stb),
        .monto_stb            (monto_stb),
        .monto                (monto),
        .phase                (phase)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic longint amt_value();
        longint v = 0;
        foreach (m_amt[i]) v = v * 10 + m_amt[i];
        return v;
    endfunction

    task automatic end_session();
        m_pin.delete();
        m_amt.delete();
        m_tipo  = 1'b0;
        m_monto = 0;
    endtask

    task automatic model_step(input bit r, input bit c, input bit kv, input logic [3:0] kc,
                              input bit pi, input bit bl, input bit ba, input bit fo);
        bit active, to, is_dig;
        p_card = 0; p_add = 0; p_pdone = 0; p_mstb = 0;
        if (r) begin
            m_ph = S_IDLE; m_card_prev = 0; m_digito = 0; m_quiet = 0;
            end_session();
            return;
        end
        active = (m_ph == S_SELECT) || (m_ph == S_PIN) || (m_ph == S_AMOUNT);
        if (active && !kv) m_quiet++; else m_quiet = 0;
        to = TO_EN && (m_quiet == TO_CYC);
        is_dig = (kc <= 4'd9);
        if (bl) begin
            m_ph = S_LOCKED;
        end else if (m_ph != S_IDLE && m_ph != S_LOCKED && !c) begin
            m_ph = S_IDLE;
            end_session();
        end else if (active && ((kv && kc == KEY_CANCEL) || to)) begin
            m_ph = S_WAIT_REMOVE;
        end else begin
            case (m_ph)
                S_IDLE: if (c && !m_card_prev) begin p_card = 1; m_ph = S_SELECT; end
                S_SELECT: if (kv && (kc == KEY_DEPOSIT || kc == KEY_WITHDRAW)) begin
                    m_tipo = (kc == KEY_WITHDRAW);
                    m_ph = S_PIN;
                end
                S_PIN: if (kv) begin
                    if (is_dig) begin
                        if (m_pin.size() < 4) begin m_pin.push_back(int'(kc)); m_digito = int'(kc); p_add = 1; end
                    end else if (kc == KEY_ENTER && m_pin.size() == 4) begin
                        p_pdone = 1; m_ph = S_AMOUNT;
                    end else if (kc == KEY_CLEAR) m_pin.delete();
                end
                S_AMOUNT: if (pi) begin
                    m_pin.delete(); m_amt.delete(); m_ph = S_PIN;
                end else if (kv) begin
                    if (is_dig) begin
                        if (m_amt.size() < 9) m_amt.push_back(int'(kc));
                    end else if (kc == KEY_CLEAR) m_amt.delete();
                    else if (kc == KEY_ENTER && m_amt.size() > 0) begin
                        m_monto = amt_value(); p_mstb = 1; m_ph = S_DONE;
                    end
                end
                S_DONE: if (ba || fo) m_ph = S_WAIT_REMOVE;
                default: ;
            endcase
        end
        m_card_prev = c;
    endtask

    task automatic step(input bit r, input bit kv, input logic [3:0] kc,
                        input bit pi, input bit bl, input bit ba, input bit fo);
        rst = r; card_in = cur_card; key_valid = kv; key_code = kc;
        pin_incorrecto = pi; bloqueo = bl; balance_actualizado = ba; fondos_insuficientes = fo;
        model_step(r, cur_card, kv, kc, pi, bl, ba, fo);
        @(posedge clk);
        #1;
        if (add_digit === 1'b1) add_seen++;
        check("phase", 64'(phase), 64'(m_ph));
        check("tarjeta_recibida", 64'(tarjeta_recibida), 64'(p_card));
        check("add_digit", 64'(add_digit), 64'(p_add));
        check("digito", 64'(digito), 64'(m_digito));
        check("digito_stb", 64'(digito_stb), 64'(p_pdone));
        check("monto_stb", 64'(monto_stb), 64'(p_mstb));
        check("monto", 64'(monto), 64'(m_monto));
        check("tipo_trans", 64'(tipo_trans), 64'(m_tipo));
    endtask

    task automatic key(input logic [3:0] kc);
        step(1'b0, 1'b1, kc, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int locked_cnt;
        bit r, kv, pi, bl, ba, fo;
        logic [3:0] kc;
        int sel;

        step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_phase", 64'(phase), 64'(S_IDLE));

        // card in, withdraw, PIN 4756, ENTER
        cur_card = 1'b1;
        idle(1);
        key(KEY_WITHDRAW);
        add_seen = 0;
        key(4'd4); key(4'd7); key(4'd5); key(4'd6);
        key(KEY_ENTER);
        check("t1_add_count", 64'(add_seen), 64'd4);
        check("t1_tipo", 64'(tipo_trans), 64'd1);
        check("t1_phase_amount", 64'(phase), 64'(S_AMOUNT));

        // amount 1200
        key(4'd1); key(4'd2); key(4'd0); key(4'd0);
        key(KEY_ENTER);
        check("t2_monto", 64'(monto), 64'd1200);
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        cur_card = 1'b0;
        idle(2);

        // new deposit session; empty ENTER in AMOUNT ignored
        cur_card = 1'b1;
        idle(1);
        key(KEY_DEPOSIT);
        key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(KEY_ENTER);
        key(KEY_ENTER);
        check("t2_empty_enter", 64'(phase), 64'(S_AMOUNT));

        // pin_incorrecto returns to PIN with counts cleared
        key(4'd1); key(4'd2);
        step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t4_pin_reject", 64'(phase), 64'(S_PIN));

        // short PIN ENTER ignored, CLEAR, fifth digit dropped
        key(4'd4); key(4'd7); key(KEY_ENTER);
        check("t3_short_enter", 64'(phase), 64'(S_PIN));
        key(KEY_CLEAR);
        add_seen = 0;
        key(4'd4); key(4'd7); key(4'd5); key(4'd6); key(4'd9);
        check("t3_add_count", 64'(add_seen), 64'd4);
        check("t3_digito", 64'(digito), 64'd6);
        key(KEY_ENTER);

        // ten nines keep only nine digits
        for (int i = 0; i < 10; i++) key(4'd9);
        key(KEY_ENTER);
        check("t4_monto_max", 64'(monto), 64'd999999999);
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        cur_card = 1'b0;
        idle(1);

        // bloqueo in PIN locks until reset
        cur_card = 1'b1;
        idle(1);
        key(KEY_WITHDRAW); key(4'd1); key(4'd2);
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        key(4'd3); key(KEY_ENTER);
        check("t5_locked", 64'(phase), 64'(S_LOCKED));
        cur_card = 1'b0;
        idle(2);
        check("t5_locked_no_card", 64'(phase), 64'(S_LOCKED));
        step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);

        // card removed mid-AMOUNT: back to IDLE, no monto_stb
        cur_card = 1'b1;
        idle(1);
        key(KEY_DEPOSIT);
        key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(KEY_ENTER);
        key(4'd5);
        cur_card = 1'b0;
        key(4'd6);
        check("t5_removed", 64'(phase), 64'(S_IDLE));
        check("t5_monto_cleared", 64'(monto), 64'd0);

        // inactivity in PIN
        cur_card = 1'b1;
        idle(1);
        key(KEY_WITHDRAW); key(4'd1);
        idle(20);
        check("t6_timeout", 64'(phase), 64'(TO_EN ? S_WAIT_REMOVE : S_PIN));
        cur_card = 1'b0;
        idle(1);

        // randomized sessions
        locked_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            case (m_ph)
                S_IDLE:        if ($urandom_range(0, 3) == 0) cur_card = 1'b1;
                S_WAIT_REMOVE: if ($urandom_range(0, 2) == 0) cur_card = 1'b0;
                S_LOCKED:      ;
                default:       if ($urandom_range(0, 149) == 0) cur_card = 1'b0;
            endcase
            locked_cnt = (m_ph == S_LOCKED) ? locked_cnt + 1 : 0;
            r  = (locked_cnt >= 20) || ($urandom_range(0, 999) == 0);
            kv = ($urandom_range(0, 9) < 6);
            sel = $urandom_range(0, 9);
            if (sel < 5)       kc = 4'($urandom_range(0, 9));
            else if (sel == 5) kc = KEY_ENTER;
            else if (sel == 6) kc = KEY_CLEAR;
            else if (sel == 7) kc = ($urandom_range(0, 1) == 0) ? KEY_DEPOSIT : KEY_WITHDRAW;
            else if (sel == 8) kc = 4'($urandom_range(0, 9));
            else               kc = 4'($urandom_range(0, 15));
            pi = ($urandom_range(0, 39) == 0);
            bl = ($urandom_range(0, 799) == 0);
            ba = ($urandom_range(0, 7) == 0);
            fo = ($urandom_range(0, 7) == 0);
            step(r, kv, kc, pi, bl, ba, fo);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
